pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before retry.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: timeouts tolerated before FAULT (max 15).
REQ-005 SHALL have ports:
- clock  in  1  free-running PLL reference clock (25 MHz), single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- locked  in  1  PLL LOCK, asynchronous to clock.
- soft_rst  in  1  one-cycle relock request.
- fault_clr  in  1  one-cycle FAULT acknowledge.
- pll_rst  out  1  drives PLL RST, active-high.
- sys_rst_n  out  1  downstream reset, active-low.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- lock_lost  out  1  one-cycle pulse on lock loss in RUN.
- retry_cnt  out  4  timeouts in current attempt sequence.
- state  out  3  encoded current state.

Function
REQ-006 SHALL pass locked through a 2-flop synchronizer; lock_s follows locked 2 clock edges later.
REQ-007 SHALL implement states RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT, with one shared cycle counter cleared on every state entry.
REQ-008 All outputs SHALL be registered, decoded from the state register (lock_lost registered in the same edge as the RUN->RESET_PLL transition).
REQ-009 RESET_PLL: pll_rst=1, sys_rst_n=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-010 WAIT_LOCK: pll_rst=0, sys_rst_n=0; lock_s=1 -> STABILIZE next edge; counter reaching LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> RESET_PLL with retry_cnt+1 if retry_cnt<MAX_RETRIES, else FAULT with retry_cnt unchanged.
REQ-011 STABILIZE: sys_rst_n=0; lock_s=0 -> WAIT_LOCK without retry increment; counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN.
REQ-012 RUN: sys_rst_n=1, ready=1, retry_cnt cleared on entry; lock_s=0 -> RESET_PLL and lock_lost=1 for one cycle, sys_rst_n=0 from the same edge.
REQ-013 FAULT: pll_rst=1, sys_rst_n=0, fault=1; leaves only on fault_clr -> RESET_PLL with retry_cnt=0.
REQ-014 soft_rst in any state except FAULT SHALL force RESET_PLL with retry_cnt=0 next edge; soft_rst has priority over every lock/timeout event in the same cycle; soft_rst in FAULT is ignored.
REQ-015 Counter SHALL be wide enough for max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES) and SHALL never wrap within a state.
REQ-016 Glitch of lock_s shorter than LOCK_STABLE_CYCLES during STABILIZE SHALL restart stabilization; sys_rst_n SHALL never deassert before LOCK_STABLE_CYCLES continuous lock cycles.

Reset
REQ-017 On reset_n=0 (asynchronous): state=RESET_PLL, counter=0, retry_cnt=0, synchronizer flops=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, lock_lost=0.
REQ-018 Reset deassertion mid-operation SHALL restart the full sequence from RESET_PLL; reset_n assertion SHALL take effect without a clock edge.

Structure
REQ-019 State encoding constants (RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4) SHALL live in shared package pll_seq_pkg.
REQ-020 Synchronizer SHALL be a separate sub-module sync_2ff (async active-low reset, reset value 0), reusable elsewhere.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-021 Release reset, raise locked at cycle 10 and hold -> pll_rst low cycles 4..; sys_rst_n=1, ready=1 exactly 2+1+8 edges after locked rises.
REQ-022 locked held 0 -> three timeouts each 32 cycles after 4-cycle pll_rst pulses, retry_cnt 1,2, then FAULT with fault=1, pll_rst=1; fault_clr -> RESET_PLL, retry_cnt=0.
REQ-023 In STABILIZE drop locked for 1 cycle at stable count 5 -> WAIT_LOCK, then STABILIZE restarts, ready only after 8 clean cycles.
REQ-024 In RUN drop locked -> lock_lost one-cycle pulse, sys_rst_n=0 and pll_rst=1 3 edges after drop, retry_cnt=0.
REQ-025 soft_rst coincident with timeout in WAIT_LOCK at retry_cnt=2 -> RESET_PLL, retry_cnt=0, fault stays 0; reset_n pulsed mid-RUN -> all outputs at REQ-017 values immediately.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and sizing helper for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock/stabilize sequencing with retry, fault and relock handling
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       soft_rst,
    input  logic       fault_clr,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int cw = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [cw-1:0] rst_last = cw'(PLL_RST_CYCLES - 1);
    localparam logic [cw-1:0] tmo_last = cw'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [cw-1:0] stb_last = cw'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    max_r    = 4'(MAX_RETRIES);

    seq_state_t    st, nxt;
    logic [cw-1:0] cnt, nxt_cnt;
    logic [3:0]    nxt_retry;
    logic          lock_s, restart, nxt_lost;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked),
        .q       (lock_s)
    );

    always_comb begin
        nxt       = st;
        nxt_retry = retry_cnt;
        nxt_lost  = 1'b0;
        restart   = 1'b0;
        if (soft_rst && st != FAULT) begin
            nxt       = RESET_PLL;
            nxt_retry = '0;
            restart   = 1'b1;
        end else begin
            case (st)
                RESET_PLL: nxt = (cnt == rst_last) ? WAIT_LOCK : RESET_PLL;
                WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt = STABILIZE;
                    end else if (cnt == tmo_last) begin
                        nxt       = (retry_cnt < max_r) ? RESET_PLL : FAULT;
                        nxt_retry = (retry_cnt < max_r) ? retry_cnt + 4'd1 : retry_cnt;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        nxt = WAIT_LOCK;
                    end else if (cnt == stb_last) begin
                        nxt       = RUN;
                        nxt_retry = '0;
                    end
                end
                RUN: begin
                    nxt      = lock_s ? RUN : RESET_PLL;
                    nxt_lost = !lock_s;
                end
                FAULT: begin
                    nxt       = fault_clr ? RESET_PLL : FAULT;
                    nxt_retry = fault_clr ? 4'd0 : retry_cnt;
                end
                default: nxt = RESET_PLL;
            endcase
        end
        // saturating so long RUN/FAULT residency never wraps the counter
        nxt_cnt = (restart || nxt != st) ? '0 : ((&cnt) ? cnt : cnt + cw'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st        <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            st        <= nxt;
            cnt       <= nxt_cnt;
            retry_cnt <= nxt_retry;
            pll_rst   <= (nxt == RESET_PLL) || (nxt == FAULT);
            sys_rst_n <= (nxt == RUN);
            ready     <= (nxt == RUN);
            fault     <= (nxt == FAULT);
            lock_lost <= nxt_lost;
        end
    end

    assign state = st;

endmodule
